// File: rtl/prod_accum.sv
// Accumulates COUNT unsigned 16-bit products into a SUM_W-bit sum and presents it
// until the downstream takes it. Overflow (wrap past 2^SUM_W) is flagged sticky.
module prod_accum #(
  parameter int COUNT = 4,
  parameter int SUM_W = 24
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [15:0]      result_bits_data,
  input  logic             result_rdy,
  output logic             result_taken,
  input  logic             acc_clear,
  output logic [SUM_W-1:0] sum_bits_data,
  output logic             sum_valid,
  input  logic             sum_taken,
  output logic             sum_ovf
);

  typedef enum logic [0:0] {ACCUM = 1'b0, DONE = 1'b1} state_t;

  localparam logic [7:0] CNT_LAST = 8'(COUNT - 1);

  state_t           state_r, state_next_s;
  logic [7:0]       cnt_r, cnt_next_s;
  logic [SUM_W-1:0] acc_r, acc_next_s;
  logic             blk_r, blk_next_s;
  logic             taken_r, taken_next_s;
  logic             valid_r, valid_next_s;
  logic             ovf_r, ovf_next_s;
  logic [SUM_W:0]   sum_full_s;

  // One extra bit captures the carry out of the accumulator.
  assign sum_full_s = {1'b0, acc_r} + {{(SUM_W - 15){1'b0}}, result_bits_data};

  // Next-state and next-output logic; blk masks the cycle after each take.
  always_comb begin
    state_next_s = state_r;
    cnt_next_s   = cnt_r;
    acc_next_s   = acc_r;
    blk_next_s   = 1'b0;
    taken_next_s = 1'b0;
    valid_next_s = valid_r;
    ovf_next_s   = ovf_r;
    case (state_r)
      ACCUM: begin
        if (acc_clear) begin
          cnt_next_s = 8'd0;
          acc_next_s = {SUM_W{1'b0}};
          ovf_next_s = 1'b0;
        end else if (blk_r) begin
          blk_next_s = 1'b0;
        end else if (result_rdy) begin
          acc_next_s   = sum_full_s[SUM_W-1:0];
          ovf_next_s   = ovf_r | sum_full_s[SUM_W];
          taken_next_s = 1'b1;
          blk_next_s   = 1'b1;
          if (cnt_r == CNT_LAST) begin
            state_next_s = DONE;
            valid_next_s = 1'b1;
            cnt_next_s   = 8'd0;
          end else begin
            cnt_next_s = cnt_r + 8'd1;
          end
        end else begin
          blk_next_s = 1'b0;
        end
      end
      DONE: begin
        if (sum_taken) begin
          state_next_s = ACCUM;
          cnt_next_s   = 8'd0;
          acc_next_s   = {SUM_W{1'b0}};
          ovf_next_s   = 1'b0;
          valid_next_s = 1'b0;
        end else begin
          state_next_s = DONE;
        end
      end
      default: begin
        state_next_s = ACCUM;
        cnt_next_s   = 8'd0;
        acc_next_s   = {SUM_W{1'b0}};
        ovf_next_s   = 1'b0;
        valid_next_s = 1'b0;
      end
    endcase
  end

  // State and output registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r <= ACCUM;
      cnt_r   <= 8'd0;
      acc_r   <= {SUM_W{1'b0}};
      blk_r   <= 1'b0;
      taken_r <= 1'b0;
      valid_r <= 1'b0;
      ovf_r   <= 1'b0;
    end else begin
      state_r <= state_next_s;
      cnt_r   <= cnt_next_s;
      acc_r   <= acc_next_s;
      blk_r   <= blk_next_s;
      taken_r <= taken_next_s;
      valid_r <= valid_next_s;
      ovf_r   <= ovf_next_s;
    end
  end

  assign result_taken  = taken_r;
  assign sum_bits_data = acc_r;
  assign sum_valid     = valid_r;
  assign sum_ovf       = ovf_r;

endmodule

// File: tb/tb_prod_accum.sv
// Scoreboard bench: two instances (SUM_W=24 and SUM_W=17, COUNT=4) share stimulus;
// expected sums are queued per instance and checked when sum_valid rises.
module tb_prod_accum;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] data;
  logic        rdy;
  logic        acc_clear;
  logic        sum_taken;
  logic [1:0]  taken_v, valid_v, ovf_v;
  logic [23:0] sum_a;
  logic [16:0] sum_b;

  typedef struct {longint sum; bit ovf;} exp_t;
  exp_t qa[$];
  exp_t qb[$];

  int checks = 0;
  int errors = 0;
  int taken_cnt = 0;
  bit prev_valid [2];
  bit prev_taken [2];
  exp_t held [2];

  always #5 clk = ~clk;

  prod_accum #(.COUNT(4), .SUM_W(24)) dut_a (
    .clk(clk), .reset(reset), .result_bits_data(data), .result_rdy(rdy),
    .result_taken(taken_v[0]), .acc_clear(acc_clear), .sum_bits_data(sum_a),
    .sum_valid(valid_v[0]), .sum_taken(sum_taken), .sum_ovf(ovf_v[0]));

  prod_accum #(.COUNT(4), .SUM_W(17)) dut_b (
    .clk(clk), .reset(reset), .result_bits_data(data), .result_rdy(rdy),
    .result_taken(taken_v[1]), .acc_clear(acc_clear), .sum_bits_data(sum_b),
    .sum_valid(valid_v[1]), .sum_taken(sum_taken), .sum_ovf(ovf_v[1]));

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic longint sum_of(input int i);
    return (i == 0) ? longint'(sum_a) : longint'(sum_b);
  endfunction

  // Monitor: pop expectation on sum_valid rise, then check the presented sum holds.
  always @(negedge clk) begin
    if (reset) begin
      for (int i = 0; i < 2; i++) begin
        if (valid_v[i]) begin
          if (!prev_valid[i]) begin
            exp_t e;
            if ((i == 0 && qa.size() == 0) || (i == 1 && qb.size() == 0)) begin
              chk($sformatf("unexpected_sum%0d", i), 64'(sum_of(i)), 64'hFFFF_FFFF);
            end else begin
              e = (i == 0) ? qa.pop_front() : qb.pop_front();
              held[i] = e;
              chk($sformatf("sum%0d", i), 64'(sum_of(i)), 64'(e.sum));
              chk($sformatf("ovf%0d", i), 64'(ovf_v[i]), 64'(e.ovf));
              chk($sformatf("taken_at_done%0d", i), 64'(taken_v[i]), 64'd1);
            end
          end else begin
            chk($sformatf("done_taken%0d", i), 64'(taken_v[i]), 64'd0);
            chk($sformatf("done_hold%0d", i), 64'(sum_of(i)), 64'(held[i].sum));
            chk($sformatf("done_ovf%0d", i), 64'(ovf_v[i]), 64'(held[i].ovf));
          end
        end
        if (taken_v[i]) begin
          chk($sformatf("pulse_width%0d", i), 64'(prev_taken[i]), 64'd0);
          if (i == 0) taken_cnt++;
        end
        prev_valid[i] = valid_v[i];
        prev_taken[i] = taken_v[i];
      end
    end else begin
      for (int i = 0; i < 2; i++) begin
        prev_valid[i] = 1'b0;
        prev_taken[i] = 1'b0;
      end
    end
  end

  task automatic push(input longint a, input bit ao, input longint b, input bit bo);
    exp_t e;
    e.sum = a; e.ovf = ao; qa.push_back(e);
    e.sum = b; e.ovf = bo; qb.push_back(e);
  endtask

  // Offer one product after gap idle cycles; drop ready once the take is seen.
  task automatic send(input logic [15:0] v, input int gap);
    bit seen = 1'b0;
    for (int g = 0; g < gap; g++) @(negedge clk);
    data = v;
    rdy  = 1'b1;
    for (int k = 0; k < 50 && !seen; k++) begin
      @(negedge clk);
      if (taken_v[0]) seen = 1'b1;
    end
    rdy = 1'b0;
    if (!seen) chk("send_timeout", 64'd0, 64'd1);
  endtask

  task automatic take_sum();
    @(negedge clk);
    sum_taken = 1'b1;
    @(negedge clk);
    sum_taken = 1'b0;
    chk("clr_valid_a", 64'(valid_v[0]), 64'd0);
    chk("clr_sum_a", 64'(sum_a), 64'd0);
    chk("clr_ovf_b", 64'(ovf_v[1]), 64'd0);
    chk("clr_sum_b", 64'(sum_b), 64'd0);
  endtask

  initial begin
    int t0;
    logic [6:0] pat;
    reset = 1'b0; data = 16'd0; rdy = 1'b0; acc_clear = 1'b0; sum_taken = 1'b0;
    #3;
    chk("rst_taken", 64'(taken_v), 64'd0);
    chk("rst_valid", 64'(valid_v), 64'd0);
    chk("rst_ovf", 64'(ovf_v), 64'd0);
    chk("rst_sum", 64'({sum_a, sum_b}), 64'd0);
    @(negedge clk); @(negedge clk);
    reset = 1'b1;

    // 56 held ready: pulses every other edge, then DONE held 10 cycles.
    push(224, 1'b0, 224, 1'b0);
    @(negedge clk);
    data = 16'd56; rdy = 1'b1;
    for (int k = 0; k < 7; k++) begin
      @(negedge clk);
      pat[k] = taken_v[0];
      if (k == 5) chk("valid_before_last", 64'(valid_v[0]), 64'd0);
    end
    chk("held_pattern", 64'(pat), 64'b1010101);
    chk("latency_valid", 64'(valid_v[0]), 64'd1);
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      acc_clear = (k == 4);
    end
    acc_clear = 1'b0;
    rdy = 1'b0;
    take_sum();

    // Irregular gaps; a stray sum_taken in ACCUM must be ignored.
    push(1000, 1'b0, 1000, 1'b0);
    t0 = taken_cnt;
    send(16'd100, 0);
    sum_taken = 1'b1; @(negedge clk); sum_taken = 1'b0;
    send(16'd200, 3);
    send(16'd300, 5);
    send(16'd400, 1);
    for (int k = 0; k < 4; k++) @(negedge clk);
    chk("take_count", 64'(taken_cnt - t0), 64'd4);
    take_sum();

    // Maximum products: wraps only in the 17-bit instance.
    push(262140, 1'b0, 131068, 1'b1);
    for (int k = 0; k < 4; k++) send(16'hFFFF, 0);
    @(negedge clk);
    take_sum();

    // Clear after two accepts beats a coincident ready.
    push(40, 1'b0, 40, 1'b0);
    send(16'd10, 0);
    send(16'd10, 0);
    @(negedge clk);
    acc_clear = 1'b1; data = 16'd10; rdy = 1'b1;
    @(negedge clk);
    chk("clear_no_take", 64'(taken_v), 64'd0);
    chk("clear_acc", 64'(sum_a), 64'd0);
    acc_clear = 1'b0; rdy = 1'b0;
    for (int k = 0; k < 4; k++) send(16'd10, 0);
    @(negedge clk);
    take_sum();

    // Asynchronous reset mid-accumulation, then restart from zero.
    for (int k = 0; k < 3; k++) send(16'd5, 0);
    #2 reset = 1'b0;
    #1;
    chk("async_taken", 64'(taken_v), 64'd0);
    chk("async_sum", 64'({sum_a, sum_b}), 64'd0);
    chk("async_valid", 64'(valid_v), 64'd0);
    @(negedge clk); @(negedge clk);
    push(28, 1'b0, 28, 1'b0);
    reset = 1'b1; data = 16'd7; rdy = 1'b1;
    @(negedge clk);
    chk("first_edge_take", 64'(taken_v), 64'b11);
    rdy = 1'b0;
    for (int k = 0; k < 3; k++) send(16'd7, 0);
    @(negedge clk);
    take_sum();

    for (int k = 0; k < 3; k++) @(negedge clk);
    chk("queue_a_empty", 64'(qa.size()), 64'd0);
    chk("queue_b_empty", 64'(qb.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
